// File: rtl/trig_seq_pkg.sv
// Shared definitions for the trigger sequencer.
// Holds the register map, the mode register bit positions and the FSM state type.
package trig_seq_pkg;

    // Register addresses on the wa bus
    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_DELAY  = 2'd1;
    localparam logic [1:0] REG_MODE   = 2'd2;
    localparam logic [1:0] REG_WIDTH  = 2'd3;

    // Bit positions inside the mode register
    localparam int MODE_EXT_EN  = 0;
    localparam int MODE_EXT_POL = 1;
    localparam int MODE_SOFT    = 2;
    localparam int MODE_OVR_CLR = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

endpackage

// File: rtl/trig_in_sync.sv
// External trigger input conditioning.
// Brings the asynchronous trigger pin into the pclk domain through three flops,
// applies the polarity selection before the first flop, and flags the rising
// edge of the polarity-corrected signal.
//
// Ports:
//   pclk     pixel clock
//   rst      synchronous active-high reset
//   ext_in   asynchronous trigger pin
//   ext_pol  1 = falling edge of the pin is the active edge
//   ext_en   enables the event output
//   ext_evt  one-cycle event on each active edge
module trig_in_sync (
    input  logic pclk,
    input  logic rst,
    input  logic ext_in,
    input  logic ext_pol,
    input  logic ext_en,
    output logic ext_evt
);

    logic s0;
    logic s1;
    logic s2;

    // Synchroniser chain; s0/s1 resolve metastability, s2 is the edge history
    always_ff @(posedge pclk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= ext_in ^ ext_pol;
            s1 <= s0;
            s2 <= s1;
        end
    end

    // Only a fresh rising edge counts, so a held level produces a single event
    assign ext_evt = ext_en & s1 & ~s2;

endmodule

// File: rtl/trig_sequencer.sv
// Trigger sequencer feeding the sensor readout controller.
// Merges an external pin trigger, an internal period generator and a software
// one-shot into one event stream. Each accepted event is delayed by a
// programmable number of cycles and then produces a trig_out pulse of
// programmable width. Events arriving while a trigger is in flight are dropped
// and counted in a saturating overrun counter.
//
// Ports:
//   pclk         pixel clock, the only clock
//   rst          synchronous active-high reset
//   wen/wa/wd    register write port (0 period, 1 delay, 2 mode, 3 width)
//   ext_in       asynchronous external trigger pin
//   trig_out     registered trigger pulse
//   busy         high while a trigger is in flight (DELAY or PULSE)
//   event_irq    one-cycle pulse on each accepted event
//   overrun_cnt  saturating count of dropped events
module trig_sequencer
    import trig_seq_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OVR_W = 8
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             wen,
    input  logic [1:0]       wa,
    input  logic [CNT_W-1:0] wd,
    input  logic             ext_in,
    output logic             trig_out,
    output logic             busy,
    output logic             event_irq,
    output logic [OVR_W-1:0] overrun_cnt
);

    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] delay_reg;
    logic [CNT_W-1:0] width_reg;
    logic             ext_en;
    logic             ext_pol;
    logic             soft_shot;
    logic             ovr_clr;

    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] width_load;
    logic             per_active;
    logic             per_evt;
    logic             ext_evt;
    logic             evt;
    logic             overrun;
    state_t           state;

    // Register file; soft-shot and overrun-clear are one-cycle strobes
    always_ff @(posedge pclk) begin
        if (rst) begin
            period_reg <= '0;
            delay_reg  <= '0;
            width_reg  <= '0;
            ext_en     <= 1'b0;
            ext_pol    <= 1'b0;
            soft_shot  <= 1'b0;
            ovr_clr    <= 1'b0;
        end else begin
            soft_shot <= 1'b0;
            ovr_clr   <= 1'b0;
            if (wen) begin
                case (wa)
                    REG_PERIOD: period_reg <= wd;
                    REG_DELAY:  delay_reg  <= wd;
                    REG_MODE: begin
                        ext_en    <= wd[MODE_EXT_EN];
                        ext_pol   <= wd[MODE_EXT_POL];
                        soft_shot <= wd[MODE_SOFT];
                        ovr_clr   <= wd[MODE_OVR_CLR];
                    end
                    REG_WIDTH:  width_reg  <= wd;
                    default: ;
                endcase
            end
        end
    end

    trig_in_sync u_sync (
        .pclk    (pclk),
        .rst     (rst),
        .ext_in  (ext_in),
        .ext_pol (ext_pol),
        .ext_en  (ext_en),
        .ext_evt (ext_evt)
    );

    // Period generator: fires on the last count so events are exactly period apart
    assign per_active = (period_reg > CNT_W'(1));
    assign per_evt    = per_active && (pcnt == period_reg - CNT_W'(1));

    always_ff @(posedge pclk) begin
        if (rst) begin
            pcnt <= '0;
        end else if ((wen && wa == REG_PERIOD) || !per_active || per_evt) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + CNT_W'(1);
        end
    end

    assign evt        = ext_evt | per_evt | soft_shot;
    assign event_irq  = (state == IDLE) & evt;
    assign overrun    = (state != IDLE) & evt;
    assign width_load = (width_reg == '0) ? CNT_W'(1) : width_reg;

    // Sequencer FSM. The pulse width is captured at acceptance so a width write
    // during the delay phase only affects the following event.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            dcnt     <= '0;
            wcnt     <= '0;
            trig_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (evt) begin
                        dcnt <= delay_reg;
                        wcnt <= width_load;
                        busy <= 1'b1;
                        if (delay_reg == '0) begin
                            state    <= PULSE;
                            trig_out <= 1'b1;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    dcnt <= dcnt - CNT_W'(1);
                    if (dcnt == CNT_W'(1)) begin
                        state    <= PULSE;
                        trig_out <= 1'b1;
                    end
                end
                PULSE: begin
                    wcnt <= wcnt - CNT_W'(1);
                    if (wcnt == CNT_W'(1)) begin
                        state    <= IDLE;
                        trig_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    trig_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Overrun counter; a clear strobe beats a coincident overrun
    always_ff @(posedge pclk) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (ovr_clr) begin
            overrun_cnt <= '0;
        end else if (overrun && overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Testbench for trig_sequencer.
// Cycle numbering: cyc counts rising edges; inputs and samples happen on the
// falling edge, so "cycle c" is the interval after rising edge c.
// An event seen by the FSM in cycle n shows event_irq in n and trig_out high
// from n+1+delay for max(width,1) cycles.
module tb_trig_sequencer;
    import trig_seq_pkg::*;

    localparam int CNT_W = 32;
    localparam int OVR_W = 2;

    logic             pclk = 1'b0;
    logic             rst = 1'b1;
    logic             wen = 1'b0;
    logic [1:0]       wa = 2'd0;
    logic [CNT_W-1:0] wd = '0;
    logic             ext_in = 1'b0;
    logic             trig_out;
    logic             busy;
    logic             event_irq;
    logic [OVR_W-1:0] overrun_cnt;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int irq_cyc;
        int start_cyc;
        int width;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    bit   prev_trig = 1'b0;
    int   rise_cyc = 0;

    trig_sequencer #(
        .CNT_W (CNT_W),
        .OVR_W (OVR_W)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .wen         (wen),
        .wa          (wa),
        .wd          (wd),
        .ext_in      (ext_in),
        .trig_out    (trig_out),
        .busy        (busy),
        .event_irq   (event_irq),
        .overrun_cnt (overrun_cnt)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One register write, issued in the current cycle
    task automatic applyStimulus(input logic [1:0] addr, input logic [CNT_W-1:0] data);
        wen = 1'b1;
        wa  = addr;
        wd  = data;
        @(negedge pclk);
        wen = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge pclk);
    endtask

    task automatic expect_pulse(input int irq_c, input int start_c, input int w);
        exp_t e;
        e.irq_cyc   = irq_c;
        e.start_cyc = start_c;
        e.width     = w;
        exp_q.push_back(e);
    endtask

    // Monitor: pairs each event_irq with the next expectation and measures the pulse
    always @(negedge pclk) begin
        if (event_irq === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_irq: got event_irq at cycle %0d, expected none", cyc);
            end else begin
                cur = exp_q.pop_front();
                cur_valid = 1'b1;
                checkOutput("irq_cycle", cyc, cur.irq_cyc);
            end
        end
        if (trig_out === 1'b1 && !prev_trig) rise_cyc = cyc;
        if (trig_out !== 1'b1 && prev_trig) begin
            if (!cur_valid) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: got pulse starting at %0d, expected none", rise_cyc);
            end else begin
                checkOutput("trig_start", rise_cyc, cur.start_cyc);
                checkOutput("trig_width", cyc - rise_cyc, cur.width);
                cur_valid = 1'b0;
            end
        end
        prev_trig = (trig_out === 1'b1);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int n;
        int c;

        // Reset state
        repeat (3) @(negedge pclk);
        checkOutput("rst_trig_out", trig_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_event_irq", event_irq, 0);
        checkOutput("rst_overrun", overrun_cnt, 0);
        rst = 1'b0;
        @(negedge pclk);

        // External rising edge, no delay, width 4
        applyStimulus(REG_MODE, 32'h1);
        applyStimulus(REG_WIDTH, 32'd4);
        k = cyc;
        n = k + 2;
        expect_pulse(n, n + 1, 4);
        ext_in = 1'b1;
        wait_until(n + 1);
        checkOutput("t1_busy_start", busy, 1);
        wait_until(n + 4);
        checkOutput("t1_busy_last", busy, 1);
        wait_until(n + 5);
        checkOutput("t1_busy_clear", busy, 0);
        checkOutput("t1_overrun", overrun_cnt, 0);
        ext_in = 1'b0;
        wait_until(n + 10);

        // Period generator, delay 5, width 2, then disabled
        applyStimulus(REG_MODE, 32'h0);
        applyStimulus(REG_DELAY, 32'd5);
        applyStimulus(REG_WIDTH, 32'd2);
        c = cyc;
        n = c + 100;
        expect_pulse(n, n + 6, 2);
        expect_pulse(n + 100, n + 106, 2);
        applyStimulus(REG_PERIOD, 32'd100);
        wait_until(n + 7);
        checkOutput("t2_busy_last", busy, 1);
        wait_until(n + 8);
        checkOutput("t2_busy_clear", busy, 0);
        wait_until(n + 150);
        applyStimulus(REG_PERIOD, 32'd0);
        wait_until(n + 230);

        // Second edge during the delay is dropped and counted
        applyStimulus(REG_DELAY, 32'd50);
        applyStimulus(REG_WIDTH, 32'd10);
        applyStimulus(REG_MODE, 32'h1);
        k = cyc;
        n = k + 2;
        expect_pulse(n, n + 51, 10);
        ext_in = 1'b1;
        wait_until(k + 10);
        ext_in = 1'b0;
        wait_until(k + 20);
        ext_in = 1'b1;
        wait_until(k + 30);
        ext_in = 1'b0;
        wait_until(n + 62);
        checkOutput("t3_overrun_one", overrun_cnt, 1);
        checkOutput("t3_busy_clear", busy, 0);
        c = cyc;
        applyStimulus(REG_MODE, 32'h9);
        wait_until(c + 2);
        checkOutput("t3_overrun_cleared", overrun_cnt, 0);

        // Saturation, then clear coinciding with an overrun
        applyStimulus(REG_DELAY, 32'd0);
        applyStimulus(REG_WIDTH, 32'd40);
        n = cyc + 1;
        expect_pulse(n, n + 1, 40);
        applyStimulus(REG_MODE, 32'h5);
        for (int i = 0; i < 4; i++) begin
            wait_until(n + 4 + 8 * i);
            ext_in = 1'b1;
            wait_until(n + 8 + 8 * i);
            ext_in = 1'b0;
        end
        wait_until(n + 33);
        checkOutput("t3b_overrun_sat", overrun_cnt, 3);
        wait_until(n + 36);
        ext_in = 1'b1;
        wait_until(n + 37);
        applyStimulus(REG_MODE, 32'h9);
        wait_until(n + 39);
        checkOutput("t3b_clear_wins", overrun_cnt, 0);
        wait_until(n + 42);
        ext_in = 1'b0;
        wait_until(n + 45);

        // Soft-shot coincident with the period event, then width 0
        applyStimulus(REG_WIDTH, 32'd3);
        c = cyc;
        n = c + 10;
        expect_pulse(n, n + 1, 3);
        expect_pulse(n + 10, n + 11, 3);
        expect_pulse(n + 20, n + 21, 1);
        applyStimulus(REG_PERIOD, 32'd10);
        wait_until(c + 9);
        applyStimulus(REG_MODE, 32'h5);
        wait_until(n + 12);
        applyStimulus(REG_WIDTH, 32'd0);
        wait_until(n + 25);
        checkOutput("t4_overrun_unchanged", overrun_cnt, 0);
        applyStimulus(REG_PERIOD, 32'd0);
        wait_until(n + 35);

        // Falling-edge polarity: only falling edges of the pin trigger
        applyStimulus(REG_MODE, 32'h0);
        ext_in = 1'b1;
        repeat (4) @(negedge pclk);
        applyStimulus(REG_MODE, 32'h2);
        repeat (4) @(negedge pclk);
        applyStimulus(REG_MODE, 32'h3);
        repeat (4) @(negedge pclk);
        k = cyc;
        expect_pulse(k + 2, k + 3, 1);
        ext_in = 1'b0;
        wait_until(k + 10);
        ext_in = 1'b1;
        wait_until(k + 20);
        expect_pulse(k + 22, k + 23, 1);
        ext_in = 1'b0;
        wait_until(k + 30);
        checkOutput("t5_overrun", overrun_cnt, 0);
        applyStimulus(REG_MODE, 32'h0);
        repeat (4) @(negedge pclk);

        // Reset in the middle of a pulse truncates it after five cycles
        applyStimulus(REG_WIDTH, 32'd20);
        n = cyc + 1;
        expect_pulse(n, n + 1, 5);
        applyStimulus(REG_MODE, 32'h4);
        wait_until(n + 5);
        rst = 1'b1;
        @(negedge pclk);
        checkOutput("t6_trig_out", trig_out, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_event_irq", event_irq, 0);
        checkOutput("t6_overrun", overrun_cnt, 0);
        rst = 1'b0;
        wait_until(n + 9);
        checkOutput("t6_no_residual", trig_out, 0);

        // After reset the width register is back to 0, so a 1-cycle pulse follows
        n = cyc + 1;
        expect_pulse(n, n + 1, 1);
        applyStimulus(REG_MODE, 32'h4);
        wait_until(n + 6);

        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("pulse_pending", cur_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
